// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit
// per clock. A single full-subtractor cell plus a registered borrow replaces
// WIDTH chained cells. A start/done handshake connects it to the controller.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2), default 8
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active-low
//   start  in   request, sampled only while busy = 0
//   a      in   [WIDTH] minuend, captured on accepted start
//   b      in   [WIDTH] subtrahend, captured on accepted start
//   bin    in   borrow-in, captured on accepted start
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle pulse; diff/bout valid from this cycle onward
//   diff   out  [WIDTH] a - b - bin mod 2^WIDTH
//   bout   out  borrow-out, 1 when a < b + bin (unsigned)
//   ovf    out  signed overflow; present only with SERIAL_SUB_OVF_EN defined
//
// Build option:
//   SERIAL_SUB_OVF_EN  adds the ovf output and its operand-sign latches.
//
// Timing: accepting edge T0, RUN during cycles T0+1 .. T0+WIDTH, done high
// in cycle T0+WIDTH+1. With start held high a new operation is accepted in
// the DONE cycle, giving one result every WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 bits produced so far; the final bit is merged in
    // combinationally on the last RUN cycle, so no register bit goes unused.
    logic [WIDTH-2:0] diff_sr;
    logic             br;
    logic [CW-1:0]    cnt;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell
    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] diff_full;

    always_comb begin
        x         = a_sr[0];
        y         = b_sr[0];
        d         = x ^ y ^ br;
        br_next   = (~x & y) | (~(x ^ y) & br);
        diff_full = {d, diff_sr};
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_full[WIDTH-1:1];
                    br      <= br_next;
                    if (cnt == LAST_BIT) begin
                        // Last bit: publish result; counter stays put so it
                        // never wraps inside an operation.
                        diff  <= diff_full;
                        bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected held outputs from the most recent completed operation
    logic [WIDTH-1:0] last_diff;
    logic             last_bout;
    logic             last_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete operation from IDLE; optional start pulse during RUN.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tbin, input logic poke);
        logic [WIDTH:0] r;
        logic           e_ovf;
        int             lat;
        int             busy_n;
        r     = {1'b0, ta} - {1'b0, tb_} - {{WIDTH{1'b0}}, tbin};
        e_ovf = (ta[WIDTH-1] != tb_[WIDTH-1]) && (r[WIDTH-1] != ta[WIDTH-1]);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        tick;
        start = 1'b0;
        // Operand changes during RUN must not matter
        a = ~ta; b = ~tb_; bin = ~tbin;
        lat = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            if (lat == 3) begin
                check("hold_diff", 32'(diff), 32'(last_diff));
                check("hold_bout", 32'(bout), 32'(last_bout));
            end
            if (poke && lat == 4) begin
                a = 8'hA5; b = 8'h11; start = 1'b1;
            end
            if (poke && lat == 5) start = 1'b0;
            tick;
            lat++;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(WIDTH + 1));
        check("busy_cycles", 32'(busy_n), 32'(WIDTH));
        check("diff", 32'(diff), 32'(r[WIDTH-1:0]));
        check("bout", 32'(bout), 32'(r[WIDTH]));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e_ovf));
`endif
        last_diff = r[WIDTH-1:0];
        last_bout = r[WIDTH];
        last_ovf  = e_ovf;
        tick;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    logic [WIDTH-1:0] ba   [4];
    logic [WIDTH-1:0] bb   [4];
    logic             bbin [4];

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
        tick;
        tick;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        tick;

        // Directed vectors
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);   // 1E, bout 0
        run_op(8'h00, 8'h01, 1'b0, 1'b0);   // FF, bout 1
        run_op(8'h10, 8'h0F, 1'b1, 1'b0);   // 00, bout 0
        run_op(8'h33, 8'h33, 1'b1, 1'b0);   // FF, bout 1
        run_op(8'h00, 8'hFF, 1'b1, 1'b0);   // 00, bout 1
        run_op(8'hFF, 8'h00, 1'b0, 1'b1);   // FF, bout 0, with ignored start
        run_op(8'h80, 8'h01, 1'b0, 1'b0);   // 7F, ovf 1
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0);   // 80, bout 1, ovf 1
        run_op(8'h05, 8'h03, 1'b0, 1'b0);   // 02, ovf 0

        // Back-to-back with start held high
        ba[0] = 8'h5A; bb[0] = 8'h3C; bbin[0] = 1'b0;
        ba[1] = 8'h00; bb[1] = 8'h01; bbin[1] = 1'b0;
        ba[2] = 8'h10; bb[2] = 8'h0F; bbin[2] = 1'b1;
        ba[3] = 8'hC3; bb[3] = 8'h3C; bbin[3] = 1'b1;
        a = ba[0]; b = bb[0]; bin = bbin[0]; start = 1'b1;
        tick;
        a = ba[1]; b = bb[1]; bin = bbin[1];
        for (int k = 0; k < 3; k++) begin
            logic [WIDTH:0] r;
            int lat;
            r = {1'b0, ba[k]} - {1'b0, bb[k]} - {{WIDTH{1'b0}}, bbin[k]};
            lat = 1;
            while (done !== 1'b1 && lat < 40) begin
                tick;
                lat++;
            end
            check("b2b_latency", 32'(lat), 32'(WIDTH + 1));
            check("b2b_diff", 32'(diff), 32'(r[WIDTH-1:0]));
            check("b2b_bout", 32'(bout), 32'(r[WIDTH]));
            last_diff = r[WIDTH-1:0];
            last_bout = r[WIDTH];
            if (k == 2) start = 1'b0;
            tick;
            a = ba[(k + 2) % 4]; b = bb[(k + 2) % 4]; bin = bbin[(k + 2) % 4];
        end
        check("b2b_idle", 32'(busy), 32'd0);
        tick;

        // Reset in the middle of RUN (bit 4)
        begin
            int seen;
            a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
            tick;
            start = 1'b0;
            repeat (4) tick;
            rst_n = 1'b0;
            tick;
            rst_n = 1'b1;
            check("mrst_busy", 32'(busy), 32'd0);
            check("mrst_done", 32'(done), 32'd0);
            check("mrst_diff", 32'(diff), 32'd0);
            check("mrst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
            check("mrst_ovf", 32'(ovf), 32'd0);
`endif
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (done === 1'b1) seen++;
                tick;
            end
            check("mrst_no_done", 32'(seen), 32'd0);
            last_diff = '0;
            last_bout = 1'b0;
            last_ovf  = 1'b0;
            run_op(8'hFF, 8'h01, 1'b0, 1'b0);   // FE, bout 0
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
